// File: rtl/snake_body_scanner_if.sv
// rtl/snake_body_scanner_if.sv - pixel query bus between the VGA controller and the snake scanner
interface snake_body_scanner_if;
    logic [9:0] Pixel_x;
    logic [9:0] Pixel_y;
    logic [1:0] Object;

    modport master (output Pixel_x, output Pixel_y, input Object);
    modport slave  (input Pixel_x, input Pixel_y, output Object);
endinterface

// File: rtl/snake_body_scanner.sv
// rtl/snake_body_scanner.sv - snake segment state, stepping, collisions and per-pixel object lookup
// Optional macro SNAKE_WRAP_EN: playfield wraps at the edges, no border wall.
module snake_body_scanner #(
    parameter int MAX_LEN = 16,
    parameter int INIT_X  = 20,
    parameter int INIT_Y  = 15
) (
    input  logic                 Clk_25mhz,
    input  logic                 Rst_n,
    snake_body_scanner_if.slave  scan,
    input  logic                 Start,
    input  logic                 Move_tick,
    input  logic [1:0]           Dir,
    input  logic                 Grow,
    output logic [5:0]           Head_x,
    output logic [4:0]           Head_y,
    output logic [5:0]           Length,
    output logic                 Game_over,
    output logic                 Hit_wall,
    output logic                 Hit_body
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [5:0] X0       = 6'(INIT_X);
    localparam logic [4:0] Y0       = 5'(INIT_Y);
    localparam logic [5:0] LEN_MAX  = 6'(MAX_LEN);
    localparam logic [5:0] LEN_INIT = 6'd3;

    logic [1:0] state, cur_dir, next_dir;
    logic [5:0] seg_x [MAX_LEN];
    logic [4:0] seg_y [MAX_LEN];
    logic [5:0] len;
    logic       grow_pending;
    logic [1:0] object_q;

    logic       step, reinit, grow_eff, wall_hit, body_hit;
    logic [1:0] ref_dir;
    logic [5:0] nh_x;
    logic [4:0] nh_y;

    // Segments past index 2 start stacked on the tail; they are hidden until Length covers them.
    function automatic logic [5:0] init_x(int i);
        return (i < 3) ? X0 - 6'(i) : X0 - 6'd2;
    endfunction

    always_comb begin
        step     = (state == ST_PLAY) && Move_tick;
        reinit   = (state == ST_OVER) && Start;
        // On a tick next_dir is being committed, so a reversal is judged against it.
        ref_dir  = Move_tick ? next_dir : cur_dir;
        grow_eff = (grow_pending || Grow) && (len < LEN_MAX);
        nh_x     = seg_x[0];
        nh_y     = seg_y[0];
        case (next_dir)
            DIR_UP:   nh_y = seg_y[0] - 5'd1;
            DIR_DOWN: nh_y = seg_y[0] + 5'd1;
            DIR_LEFT: nh_x = seg_x[0] - 6'd1;
            default:  nh_x = seg_x[0] + 6'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (nh_x == 6'd63) nh_x = 6'd39;
        if (nh_x == 6'd40) nh_x = 6'd0;
        if (nh_y == 5'd31) nh_y = 5'd29;
        if (nh_y == 5'd30) nh_y = 5'd0;
        wall_hit = 1'b0;
`else
        wall_hit = (nh_x == 6'd0) || (nh_x == 6'd39) || (nh_y == 5'd0) || (nh_y == 5'd29);
`endif
        // The tail vacates its cell on a non-growing step, so it cannot be hit.
        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((6'(i) < len) && (grow_eff || (6'(i) != len - 6'd1)) &&
                (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
                body_hit = 1'b1;
        end
    end

    always_ff @(posedge Clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= Y0;
            end
        end else if (reinit) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= Y0;
            end
        end else if (step && !wall_hit && !body_hit) begin
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nh_x;
            seg_y[0] <= nh_y;
        end
    end

    always_ff @(posedge Clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= ST_IDLE;
            cur_dir      <= DIR_RIGHT;
            next_dir     <= DIR_RIGHT;
            len          <= LEN_INIT;
            grow_pending <= 1'b0;
            Hit_wall     <= 1'b0;
            Hit_body     <= 1'b0;
        end else if (reinit) begin
            state        <= ST_IDLE;
            cur_dir      <= DIR_RIGHT;
            next_dir     <= DIR_RIGHT;
            len          <= LEN_INIT;
            grow_pending <= 1'b0;
            Hit_wall     <= 1'b0;
            Hit_body     <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && Start)
                state <= ST_PLAY;
            if (state == ST_PLAY) begin
                if (Dir != (ref_dir ^ 2'b01))
                    next_dir <= Dir;
                if (Move_tick)
                    cur_dir <= next_dir;
            end
            if (step) begin
                grow_pending <= 1'b0;
                if (wall_hit) begin
                    state    <= ST_OVER;
                    Hit_wall <= 1'b1;
                end else if (body_hit) begin
                    state    <= ST_OVER;
                    Hit_body <= 1'b1;
                end else if (grow_eff) begin
                    len <= len + 6'd1;
                end
            end else if (Grow) begin
                grow_pending <= 1'b1;
            end
        end
    end

    logic [5:0] cell_x;
    logic [4:0] cell_y;
    logic       in_screen, on_wall, on_head, on_body;
    logic [1:0] object_d;

    always_comb begin
        cell_x    = scan.Pixel_x[9:4];
        cell_y    = scan.Pixel_y[8:4];
        in_screen = (scan.Pixel_x < 10'd640) && (scan.Pixel_y < 10'd480);
`ifdef SNAKE_WRAP_EN
        on_wall   = 1'b0;
`else
        on_wall   = (cell_x == 6'd0) || (cell_x == 6'd39) || (cell_y == 5'd0) || (cell_y == 5'd29);
`endif
        on_head   = (cell_x == seg_x[0]) && (cell_y == seg_y[0]);
        on_body   = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((6'(i) < len) && (seg_x[i] == cell_x) && (seg_y[i] == cell_y))
                on_body = 1'b1;
        end
        if (!in_screen)   object_d = 2'b00;
        else if (on_wall) object_d = 2'b11;
        else if (on_head) object_d = 2'b01;
        else if (on_body) object_d = 2'b10;
        else              object_d = 2'b00;
    end

    always_ff @(posedge Clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) object_q <= 2'b00;
        else        object_q <= object_d;
    end

    assign scan.Object = object_q;
    assign Head_x      = seg_x[0];
    assign Head_y      = seg_y[0];
    assign Length      = len;
    assign Game_over   = (state == ST_OVER);
endmodule

// File: tb/tb_snake_body_scanner.sv
// tb/tb_snake_body_scanner.sv - queue-based game model with per-cycle compare and directed scenarios
module tb_snake_body_scanner;
    localparam int MAX_LEN = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Start = 1'b0, Move_tick = 1'b0, Grow = 1'b0;
    logic [1:0] Dir = 2'b11;
    logic [5:0] Head_x, Length;
    logic [4:0] Head_y;
    logic       Game_over, Hit_wall, Hit_body;

    snake_body_scanner_if scan_if();

    snake_body_scanner #(.MAX_LEN(MAX_LEN), .INIT_X(20), .INIT_Y(15)) dut (
        .Clk_25mhz (clk),
        .Rst_n     (rst_n),
        .scan      (scan_if),
        .Start     (Start),
        .Move_tick (Move_tick),
        .Dir       (Dir),
        .Grow      (Grow),
        .Head_x    (Head_x),
        .Head_y    (Head_y),
        .Length    (Length),
        .Game_over (Game_over),
        .Hit_wall  (Hit_wall),
        .Hit_body  (Hit_body)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: snake as a queue of cells, head at index 0.
    int         m_qx[$];
    int         m_qy[$];
    int         m_state;
    int         m_cur, m_next;
    bit         m_pend, m_hw, m_hb;
    logic [1:0] m_obj;

`ifdef SNAKE_WRAP_EN
    localparam logic [1:0] WALL_OBJ = 2'b00;
`else
    localparam logic [1:0] WALL_OBJ = 2'b11;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] obj_of(int px, int py);
        int cx, cy;
        if (px >= 640 || py >= 480) return 2'b00;
        cx = px / 16;
        cy = py / 16;
`ifndef SNAKE_WRAP_EN
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 2'b11;
`endif
        if (cx == m_qx[0] && cy == m_qy[0]) return 2'b01;
        for (int i = 1; i < m_qx.size(); i++)
            if (cx == m_qx[i] && cy == m_qy[i]) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_init();
        m_qx = {20, 19, 18};
        m_qy = {15, 15, 15};
        m_state = 0;
        m_cur = 3;
        m_next = 3;
        m_pend = 1'b0;
        m_hw = 1'b0;
        m_hb = 1'b0;
    endtask

    task automatic model_edge();
        int nx, ny, lim;
        bit g, hit_w, hit_b;
        m_obj = obj_of(int'(scan_if.Pixel_x), int'(scan_if.Pixel_y));
        if (m_state == 0) begin
            if (Start) m_state = 1;
            if (Grow) m_pend = 1'b1;
        end else if (m_state == 2) begin
            if (Start) model_init();
            else if (Grow) m_pend = 1'b1;
        end else begin
            if (Move_tick) begin
                g = (m_pend || Grow) && (m_qx.size() < MAX_LEN);
                m_cur = m_next;
                nx = m_qx[0];
                ny = m_qy[0];
                case (m_cur)
                    0: ny = ny - 1;
                    1: ny = ny + 1;
                    2: nx = nx - 1;
                    default: nx = nx + 1;
                endcase
`ifdef SNAKE_WRAP_EN
                nx = (nx + 40) % 40;
                ny = (ny + 30) % 30;
                hit_w = 1'b0;
`else
                hit_w = (nx == 0 || nx == 39 || ny == 0 || ny == 29);
`endif
                lim = g ? m_qx.size() : m_qx.size() - 1;
                hit_b = 1'b0;
                for (int i = 1; i < lim; i++)
                    if (nx == m_qx[i] && ny == m_qy[i]) hit_b = 1'b1;
                if (hit_w) begin
                    m_state = 2;
                    m_hw = 1'b1;
                end else if (hit_b) begin
                    m_state = 2;
                    m_hb = 1'b1;
                end else begin
                    m_qx.push_front(nx);
                    m_qy.push_front(ny);
                    if (!g) begin
                        void'(m_qx.pop_back());
                        void'(m_qy.pop_back());
                    end
                end
                m_pend = 1'b0;
            end else if (Grow) begin
                m_pend = 1'b1;
            end
            if (int'(Dir) != (m_cur ^ 1)) m_next = int'(Dir);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("object",    32'(scan_if.Object), 32'(m_obj));
            check("head_x",    32'(Head_x),    32'(m_qx[0]));
            check("head_y",    32'(Head_y),    32'(m_qy[0]));
            check("length",    32'(Length),    32'(m_qx.size()));
            check("game_over", 32'(Game_over), 32'(m_state == 2));
            check("hit_wall",  32'(Hit_wall),  32'(m_hw));
            check("hit_body",  32'(Hit_body),  32'(m_hb));
        end
    end

    task automatic clk1();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_cycle(input logic st, input logic mt, input logic gr);
        Start = st;
        Move_tick = mt;
        Grow = gr;
        scan_if.Pixel_x = 10'(16 * $urandom_range(14, 40) + $urandom_range(0, 15));
        scan_if.Pixel_y = 10'(16 * $urandom_range(12, 30) + $urandom_range(0, 15));
        clk1();
        Start = 1'b0;
        Move_tick = 1'b0;
        Grow = 1'b0;
    endtask

    task automatic probe(input int px, input int py, input logic [1:0] exp, input string name);
        scan_if.Pixel_x = 10'(px);
        scan_if.Pixel_y = 10'(py);
        clk1();
        check(name, 32'(scan_if.Object), 32'(exp));
    endtask

    task automatic apply_reset();
        chk_en = 1'b0;
        rst_n = 1'b0;
        model_init();
        m_obj = 2'b00;
        Dir = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        scan_if.Pixel_x = 10'd0;
        scan_if.Pixel_y = 10'd0;
        apply_reset();
        check("rst_length", 32'(Length), 32'd3);
        check("rst_object", 32'(scan_if.Object), 32'd0);
        check("rst_flags", {29'd0, Game_over, Hit_wall, Hit_body}, 32'd0);

        probe(328, 248, 2'b01, "probe_head");
        probe(312, 248, 2'b10, "probe_body");
        probe(5, 5, WALL_OBJ, "probe_wall");
        probe(700, 10, 2'b00, "probe_offscreen");

        do_cycle(1'b1, 1'b0, 1'b0);
        Dir = 2'b10;
        do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        check("reverse_ignored_x", 32'(Head_x), 32'd21);

        Dir = 2'b11;
        do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        check("three_steps_x", 32'(Head_x), 32'd23);
        check("three_steps_len", 32'(Length), 32'd3);
        probe(320, 240, 2'b00, "old_tail_cleared");

        do_cycle(1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b1, 1'b0);
        check("grow_then_step", 32'(Length), 32'd4);
        do_cycle(1'b0, 1'b1, 1'b1);
        check("grow_with_step", 32'(Length), 32'd5);
        repeat (13) do_cycle(1'b0, 1'b1, 1'b1);
        check("len_saturate", 32'(Length), 32'd16);
        check("head_at_38", 32'(Head_x), 32'd38);

`ifdef SNAKE_WRAP_EN
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        check("wrap_head_x", 32'(Head_x), 32'd0);
        check("wrap_no_over", 32'(Game_over), 32'd0);
        apply_reset();
`else
        do_cycle(1'b0, 1'b1, 1'b0);
        check("wall_over", 32'(Game_over), 32'd1);
        check("wall_flag", 32'(Hit_wall), 32'd1);
        check("wall_head_kept", 32'(Head_x), 32'd38);
        do_cycle(1'b0, 1'b1, 1'b0);
        check("over_tick_ignored", 32'(Head_x), 32'd38);
        do_cycle(1'b1, 1'b0, 1'b0);
        check("reinit_head_x", 32'(Head_x), 32'd20);
        check("reinit_flags", {29'd0, Game_over, Hit_wall, Hit_body}, 32'd0);
        check("reinit_length", 32'(Length), 32'd3);
`endif
        do_cycle(1'b0, 1'b1, 1'b0);
        check("idle_tick_ignored", 32'(Head_x), 32'd20);

        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b1, 1'b1);
        Dir = 2'b01; do_cycle(1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b1, 1'b0);
        Dir = 2'b10; do_cycle(1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b1, 1'b0);
        Dir = 2'b00; do_cycle(1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b1, 1'b0);
        check("self_hit_body", 32'(Hit_body), 32'd1);
        check("self_hit_wall", 32'(Hit_wall), 32'd0);
        check("self_hit_over", 32'(Game_over), 32'd1);

        do_cycle(1'b1, 1'b0, 1'b0);
        Dir = 2'b11;
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b1);
        repeat (2) begin
            Dir = 2'b01; do_cycle(1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b1, 1'b0);
            Dir = 2'b10; do_cycle(1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b1, 1'b0);
            Dir = 2'b00; do_cycle(1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b1, 1'b0);
            Dir = 2'b11; do_cycle(1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b1, 1'b0);
        end
        check("tail_chase_alive", 32'(Game_over), 32'd0);
        check("tail_chase_len", 32'(Length), 32'd4);
        check("tail_chase_head", {20'd0, Head_x, 1'b0, Head_y}, {20'd0, 6'd21, 1'b0, 5'd15});

        repeat (20) do_cycle(1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_body_scanner.md
Name: snake_body_scanner

Overview:
- Game-side responder to the VGA scan: holds snake segment state and answers "what object is at this pixel" for the Pixel_x/Pixel_y the VGA controller drives.
- Output Object feeds the VGA controller's Object input.
- Advances the snake one cell per Move_tick and detects wall and self collisions.
- Grid: 40x30 cells of 16x16 pixels on 640x480; cell_x = Pixel_x[9:4], cell_y = Pixel_y[8:4].

Parameters:
- MAX_LEN, 16, segment storage depth (2..32); Length saturates here.
- INIT_X, 20, reset head cell x.
- INIT_Y, 15, reset head cell y.

Ports:
- Clk_25mhz  input  1  pixel clock, single clock domain.
- Rst_n  input  1  asynchronous active-low reset.
- Pixel_x  input  10  current scan x from the VGA controller.
- Pixel_y  input  10  current scan y from the VGA controller.
- Start  input  1  one-cycle pulse: IDLE->PLAY, or OVER->IDLE (re-init).
- Move_tick  input  1  one-cycle step strobe.
- Dir  input  2  requested direction: 00 up, 01 down, 10 left, 11 right.
- Grow  input  1  one-cycle pulse: lengthen the snake on the next step.
- Object  output  2  00 NONE, 01 HEAD, 10 BODY, 11 WALL.
- Head_x  output  6  head cell x.
- Head_y  output  5  head cell y.
- Length  output  6  active segment count.
- Game_over  output  1  high while in OVER.
- Hit_wall  output  1  latched cause flag.
- Hit_body  output  1  latched cause flag.

Behaviour:
- Reset (async, Rst_n=0):
  - State IDLE, Length=3.
  - seg0 = (INIT_X,INIT_Y), seg1 = (INIT_X-1,INIT_Y), seg2 = (INIT_X-2,INIT_Y).
  - cur_dir = right, grow_pending=0.
  - Object=00, Game_over=0, Hit_wall=0, Hit_body=0.
  - Reset mid-step aborts the step immediately.
- States and transitions:
  - IDLE: Start -> PLAY.
  - PLAY: collision on a step -> OVER.
  - OVER: Start -> IDLE with full re-init (same values as reset).
  - Move_tick is ignored in IDLE and OVER.
- Dir sampling:
  - Dir is sampled every cycle in PLAY.
  - A request that is the exact reverse of cur_dir is ignored.
  - Otherwise it is stored as next_dir, which becomes cur_dir on the next Move_tick.
- Grow:
  - A Grow pulse sets grow_pending.
  - Grow and Move_tick in the same cycle: the growth applies to that step.
- Step (Move_tick in PLAY), completed in the same edge:
  - nh = seg0 + cur_dir offset.
  - Wall check: nh.x in {0,39} or nh.y in {0,29} -> OVER, Hit_wall=1; segments unchanged.
  - Body check: nh equals any seg[i] for i in 1..Length-1 -> OVER, Hit_body=1; segments unchanged.
  - Tail exception: the tail (i=Length-1) is excluded from the body check when not growing, since it vacates this step.
  - Both wall and body hit: Hit_wall=1 only.
  - No collision: seg[i] <= seg[i-1] for all i, seg0 <= nh.
  - If grow_pending and Length<MAX_LEN: Length++.
  - grow_pending cleared on every step, including at MAX_LEN (growth is dropped).
- Object lookup:
  - Registered, exactly 1-cycle latency from Pixel_x/Pixel_y.
  - Pixel_x>=640 or Pixel_y>=480 -> NONE.
  - Priority: WALL (border cell) > HEAD (seg0) > BODY (seg[1..Length-1]) > NONE.
  - Segments at index >= Length are never reported.
  - Lookup is active in all states, so the snake stays visible in IDLE and OVER.
  - A step and a query in the same cycle: Object reflects the pre-step segments.
- Outputs:
  - Head_x/Head_y track seg0.
  - Length is zero-extended to 6 bits.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined:
  - No border: Object never returns 11.
  - Hit_wall is held 0.
  - nh wraps modulo the grid: x 39->0 / 0->39, y 29->0 / 0->29.
  - Only a body collision ends the game.
- Undefined: border wall cells are drawn and are collision cells, as specified in Behaviour.

Test Plan:
- Reset then Pixel=(328,248) -> Object=01 one cycle later; Pixel=(312,248) -> 10; Pixel=(5,5) -> 11; Pixel=(700,10) -> 00.
- Start, Dir=11, 3 Move_ticks -> Head=(23,15), Length=3; pixel (16*20,16*15) -> 00 (old tail cleared).
- Grow pulse then Move_tick -> Length=4; Grow coincident with Move_tick -> Length=5 on that step; 13 more grows -> Length saturates at 16.
- From reset, Dir=10 (reverse) then Move_tick -> Head=(21,15) (reversal ignored).
- Drive right until nh.x=39 -> Game_over=1, Hit_wall=1, Head stays (38,15); further Move_ticks ignored; Start -> IDLE, Head=(20,15), flags=0.
- Length 5, steer down/left/up into own body -> Hit_body=1, Hit_wall=0. Length 4 tail-chase square (tail vacating) -> no collision. With SNAKE_WRAP_EN: head (38,15) moving right steps through 39 to (0,15), Game_over stays 0.
